// File: rtl/nand4_share_pkg.sv
// Shared constants and helpers for the NAND4 sharing arbiter.
package nand4_share_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 2;
  // Widest operand slice the shared reduction helper supports.
  localparam int W_MAX = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Callers zero-extend W-bit slices and truncate the result back to W bits.
  function automatic logic [W_MAX-1:0] slice_nand4(
    input logic [W_MAX-1:0] i0,
    input logic [W_MAX-1:0] i1,
    input logic [W_MAX-1:0] i2,
    input logic [W_MAX-1:0] i3
  );
    return ~(i0 & i1 & i2 & i3);
  endfunction

endpackage

// File: rtl/nand4_share_arbiter_rr_pick.sv
// Combinational round-robin priority picker starting its search at ptr.
module rr_pick
  import nand4_share_pkg::*;
#(
  parameter  int N   = N_DEF,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  localparam int unsigned NU = N;

  int unsigned    cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      cand     = (32'(ptr) + i) % NU;
      cand_idx = IDW'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
    grant[idx] = en & any;
  end

endmodule

// File: rtl/nand4_share_arbiter.sv
// N requesters share one registered W-bit NAND4 stage under round-robin arbitration.
module nand4_share_arbiter
  import nand4_share_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int W   = W_DEF,
  localparam int IDW = clog2(N)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [N-1:0]   REQ_VALID,
  output logic [N-1:0]   REQ_READY,
  input  logic [N*W-1:0] REQ_I0,
  input  logic [N*W-1:0] REQ_I1,
  input  logic [N*W-1:0] REQ_I2,
  input  logic [N*W-1:0] REQ_I3,
  output logic [W-1:0]   O,
  output logic           O_VALID,
  output logic [IDW-1:0] O_ID,
  input  logic           O_READY
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] win_idx;
  logic           win_any;
  logic           can_accept;
  logic           pick_en;
  logic           xfer;
  logic [W-1:0]   sel0, sel1, sel2, sel3;
  logic [W-1:0]   o_next;

  assign can_accept = !O_VALID || O_READY;
  assign pick_en    = can_accept && !RESET;

  rr_pick #(.N(N)) u_pick (
    .req   (REQ_VALID),
    .ptr   (ptr),
    .en    (pick_en),
    .grant (REQ_READY),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign xfer = win_any && pick_en;

  always_comb begin
    sel0     = REQ_I0[W*int'(win_idx) +: W];
    sel1     = REQ_I1[W*int'(win_idx) +: W];
    sel2     = REQ_I2[W*int'(win_idx) +: W];
    sel3     = REQ_I3[W*int'(win_idx) +: W];
    o_next   = W'(slice_nand4(W_MAX'(sel0), W_MAX'(sel1), W_MAX'(sel2), W_MAX'(sel3)));
    ptr_next = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
  end

  // A transfer takes priority over a plain drain so the slot refills without a bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      O       <= '0;
      O_VALID <= 1'b0;
      O_ID    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      O       <= o_next;
      O_ID    <= win_idx;
      O_VALID <= 1'b1;
      ptr     <= ptr_next;
    end else if (O_READY) begin
      O_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand4_share_arbiter.sv
// Directed self-checking bench for nand4_share_arbiter with N=4, W=2.
module tb_nand4_share_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQ_VALID = '0;
  logic [3:0] REQ_READY;
  logic [7:0] REQ_I0 = '0;
  logic [7:0] REQ_I1 = '0;
  logic [7:0] REQ_I2 = '0;
  logic [7:0] REQ_I3 = '0;
  logic [1:0] O;
  logic       O_VALID;
  logic [1:0] O_ID;
  logic       O_READY = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [1:0] rr_o [0:3];

  nand4_share_arbiter #(.N(4), .W(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_I0    (REQ_I0),
    .REQ_I1    (REQ_I1),
    .REQ_I2    (REQ_I2),
    .REQ_I3    (REQ_I3),
    .O         (O),
    .O_VALID   (O_VALID),
    .O_ID      (O_ID),
    .O_READY   (O_READY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [1:0] o);
    chk({tag, "_valid"}, 8'(O_VALID), 8'(v));
    chk({tag, "_id"},    8'(O_ID),    8'(id));
    chk({tag, "_o"},     8'(O),       8'(o));
  endtask

  initial begin
    rr_o[0] = 2'b00;
    rr_o[1] = 2'b01;
    rr_o[2] = 2'b10;
    rr_o[3] = 2'b11;

    // Reset with every requester valid
    RESET = 1'b1; REQ_VALID = 4'b1111; O_READY = 1'b1;
    REQ_I0 = 8'hFF; REQ_I1 = 8'hFF; REQ_I2 = 8'hFF; REQ_I3 = 8'h1B;
    tick();
    chk("rst_ready1", 8'(REQ_READY), 8'b0000);
    tick();
    chk("rst_ready2", 8'(REQ_READY), 8'b0000);
    chk_out("rst", 1'b0, 2'd0, 2'b00);

    // Round robin with all valid: slice k of I3 yields O = k
    RESET = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 8'(REQ_READY), 8'(4'b0001 << (k % 4)));
      tick();
      chk_out($sformatf("rr_out%0d", k), 1'b1, 2'(k % 4), rr_o[k % 4]);
    end

    // No idle grant, then drain leaves O/O_ID untouched
    REQ_VALID = 4'b0000;
    #1;
    chk("idle_ready", 8'(REQ_READY), 8'b0000);
    tick();
    chk_out("drain", 1'b0, 2'd0, 2'b00);

    // Single requester 2: I3 slice 2 = 01 -> O = 10; PTR becomes 3
    REQ_VALID = 4'b0100; REQ_I3 = 8'h10;
    #1;
    chk("single_ready", 8'(REQ_READY), 8'b0100);
    tick();
    chk_out("single_out", 1'b1, 2'd2, 2'b10);
    REQ_VALID = 4'b0000;
    tick();
    chk("single_drain", 8'(O_VALID), 8'd0);

    // Skip and wrap from PTR=3 with requesters 1 and 2
    REQ_VALID = 4'b0110; REQ_I3 = 8'h1B;
    #1;
    chk("skip_grant1", 8'(REQ_READY), 8'b0010);
    tick();
    chk_out("skip_out1", 1'b1, 2'd1, 2'b01);
    REQ_VALID = 4'b0100;
    #1;
    chk("skip_grant2", 8'(REQ_READY), 8'b0100);
    tick();
    chk_out("skip_out2", 1'b1, 2'd2, 2'b10);

    // Backpressure: PTR=3, requesters 0 and 1
    REQ_VALID = 4'b0011;
    #1;
    chk("bp_grant0", 8'(REQ_READY), 8'b0001);
    tick();
    chk_out("bp_first", 1'b1, 2'd0, 2'b00);
    O_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), 8'(REQ_READY), 8'b0000);
      tick();
      chk_out($sformatf("bp_hold%0d", c), 1'b1, 2'd0, 2'b00);
    end
    O_READY = 1'b1;
    #1;
    chk("bp_release_grant", 8'(REQ_READY), 8'b0010);
    tick();
    chk_out("bp_nobubble", 1'b1, 2'd1, 2'b01);
    #1;
    chk("bp_next_grant", 8'(REQ_READY), 8'b0001);
    tick();
    chk_out("bp_next_out", 1'b1, 2'd0, 2'b00);

    // Mid-operation reset discards the stalled result and clears PTR
    O_READY = 1'b0; REQ_VALID = 4'b0011;
    tick();
    chk("mid_stall_valid", 8'(O_VALID), 8'd1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ready", 8'(REQ_READY), 8'b0000);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 2'b00);
    RESET = 1'b0; O_READY = 1'b1; REQ_VALID = 4'b1111;
    #1;
    chk("mid_ptr0_grant", 8'(REQ_READY), 8'b0001);
    tick();
    chk_out("mid_after", 1'b1, 2'd0, 2'b00);
    REQ_VALID = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
